uart_port_scheduler: RTL

//  Owns the simpleuart data-register port (dat_we/re/di/do/wait) and shares it.

---
 rtl/uart_ctl_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_port_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_ctl_pkg.sv
// Shared definitions for the simpleuart data-register port scheduler.
package uart_ctl_pkg;

  // Value simpleuart presents on reg_dat_do when no received byte is waiting.
  localparam logic [31:0] UART_DAT_EMPTY = 32'hFFFF_FFFF;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requesting index strictly after the
// previous grant, wrapping modulo N. Purely combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan positions last+1 .. last+N and keep the first one that is requesting.
  always_comb begin
    logic [IW-1:0] pos;
    logic          found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(last_i) + k) % N);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_port_scheduler.sv
// Sole owner of the simpleuart data-register port. Shares the transmitter
// between NREQ byte producers (round-robin) and pumps received bytes into a
// valid/ready stream. TX and RX sides run independently.
module uart_port_scheduler
  import uart_ctl_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int TX_TIMEOUT = 20000
) (
  input  logic                    hw_clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    tx_busy,
  output logic                    tx_timeout,
  output logic                    rx_valid,
  output logic [7:0]              rx_data,
  input  logic                    rx_ready,
  output logic                    uart_dat_we,
  output logic                    uart_dat_re,
  output logic [31:0]             uart_dat_di,
  input  logic [31:0]             uart_dat_do,
  input  logic                    uart_dat_wait
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TX_TIMEOUT + 1);
  // Stall count at which the pending write is abandoned.
  localparam logic [CW-1:0] STALL_LAST = CW'(TX_TIMEOUT - 1);

  tx_state_e     state_q;
  logic [GW-1:0] grant_q;
  logic          we_q;
  logic [31:0]   di_q;
  logic          timeout_q;
  logic [CW-1:0] stall_q;

  logic          re_q;
  logic          rx_valid_q;
  logic [7:0]    rx_data_q;

  logic [NREQ-1:0] arb_gnt;
  logic [GW-1:0]   arb_idx;
  logic            arb_any;
  logic [7:0]      sel_byte_d;
  logic            rx_capture_d;

  // Only bit 31 and the low byte of the read port carry information.
  logic unused_do_bits;
  assign unused_do_bits = ^uart_dat_do[30:8];

  rr_arbiter #(
    .N  (NREQ),
    .IW (GW)
  ) u_arb (
    .req_i  (req_valid),
    .last_i (grant_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  // Byte lane of the requester the arbiter currently favours.
  always_comb begin
    sel_byte_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) sel_byte_d = req_data[8*i +: 8];
    end
  end

  // Accept strobes exist only while idle; a dropped request simply loses.
  assign req_ready = (state_q == TX_IDLE) ? arb_gnt : '0;
  assign tx_busy   = (state_q != TX_IDLE);

  // TX FSM: latch the granted byte, hold we until simpleuart accepts or the
  // stall budget runs out, then spend one gap cycle before arbitrating again.
  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      grant_q   <= GW'(NREQ - 1);
      we_q      <= 1'b0;
      di_q      <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        TX_IDLE: begin
          if (arb_any) begin
            di_q    <= {24'b0, sel_byte_d};
            we_q    <= 1'b1;
            grant_q <= arb_idx;
            stall_q <= '0;
            state_q <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (!uart_dat_wait) begin
            we_q    <= 1'b0;
            state_q <= TX_GAP;
          end else if (stall_q == STALL_LAST) begin
            we_q      <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= TX_GAP;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        TX_GAP: begin
          state_q <= TX_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // A byte is taken when one is present, there is room for it, and we are not
  // in the read-strobe cycle (do still shows the byte being popped then).
  assign rx_capture_d = !uart_dat_do[31] && (!rx_valid_q || rx_ready) && !re_q;

  // RX pump: capture into the holding register and pop simpleuart once.
  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      re_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      re_q <= rx_capture_d;
      if (rx_capture_d) begin
        rx_data_q  <= uart_dat_do[7:0];
        rx_valid_q <= 1'b1;
      end else if (rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign grant_id    = grant_q;
  assign tx_timeout  = timeout_q;
  assign uart_dat_we = we_q;
  assign uart_dat_di = di_q;
  assign uart_dat_re = re_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;

endmodule
